// File: rtl/uart_rx_fifo_tx_pkg.sv
// Shared UART definitions: FSM state encoding and frame geometry.
package uart_rx_fifo_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_rx_fifo_tx.sv
// UART transmitter plus UART receiver feeding a byte FIFO (8N1 framing).
module uart_rx_fifo_tx
  import uart_rx_fifo_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FIFO_DEPTH   = 256
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       UART_RX,
  output logic       UART_TX,
  input  logic       SEND,
  input  logic [7:0] SEND_DATA,
  output logic       READY,
  input  logic       RD_EN,
  output logic [7:0] RD_DATA,
  output logic [8:0] COUNT
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [8:0]    DEPTH_C   = 9'(FIFO_DEPTH);

  // ---------------- TX ----------------
  uart_state_e                 tx_state_q, tx_state_d;
  logic [CW-1:0]               tx_cnt_q, tx_cnt_d;
  logic [3:0]                  tx_bit_q, tx_bit_d;
  logic [FRAME_BITS-1:0]       tx_shift_q, tx_shift_d;

  // TX next state: whole frame is preloaded into a shift register and shifted out LSB first
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    if (tx_state_q == IDLE) begin
      if (SEND) begin
        tx_shift_d = {1'b1, SEND_DATA, 1'b0};
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = START;
      end
    end else if (tx_cnt_q == BIT_LAST) begin
      tx_cnt_d   = '0;
      tx_shift_d = {1'b1, tx_shift_q[FRAME_BITS-1:1]};
      tx_bit_d   = tx_bit_q + 4'd1;
      if (tx_bit_q == 4'(FRAME_BITS - 1))
        tx_state_d = IDLE;
      else if (tx_bit_q == 4'(DATA_BITS))
        tx_state_d = STOP;
      else
        tx_state_d = DATA;
    end else begin
      tx_cnt_d = tx_cnt_q + 1'b1;
    end
  end

  // TX state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // Line and READY derive from the state, so reset forces them idle immediately
  assign READY   = (tx_state_q == IDLE);
  assign UART_TX = READY ? 1'b1 : tx_shift_q[0];

  // ---------------- RX ----------------
  uart_state_e   rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_bad_q, rx_bad_d;
  logic          rx_vld_q, rx_vld_d;
  logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;

  // RX next state: synchronizer, start qualification at half bit, mid-bit sampling
  always_comb begin
    rx_s1_d    = UART_RX;
    rx_s2_d    = rx_s1_q;
    rx_prev_d  = rx_s2_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_bad_d   = rx_bad_q;
    rx_vld_d   = 1'b0;
    case (rx_state_q)
      IDLE: begin
        // sync flops reset low, so a line already low after reset is not an edge
        if (!rx_s2_q && rx_prev_q) begin
          rx_state_d = START;
          rx_cnt_d   = '0;
        end
      end
      START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          if (rx_s2_q) begin
            rx_state_d = IDLE;
          end else begin
            rx_state_d = DATA;
            rx_bit_d   = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'(DATA_BITS - 1))
            rx_state_d = STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      STOP: begin
        // a low stop bit marks the byte bad; stay here until the line recovers
        if (rx_cnt_q == BIT_LAST) begin
          if (rx_s2_q) begin
            rx_vld_d   = !rx_bad_q;
            rx_bad_d   = 1'b0;
            rx_cnt_d   = '0;
            rx_state_d = IDLE;
          end else begin
            rx_bad_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  // RX state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_s1_q    <= 1'b0;
      rx_s2_q    <= 1'b0;
      rx_prev_q  <= 1'b0;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_bad_q   <= 1'b0;
      rx_vld_q   <= 1'b0;
    end else begin
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_bad_q   <= rx_bad_d;
      rx_vld_q   <= rx_vld_d;
    end
  end

  // ---------------- FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [8:0]    count_q, count_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          do_wr, do_rd;

  // FIFO control: a pop frees a slot in the same cycle, so write+pop is legal when full
  always_comb begin
    do_rd     = RD_EN && (count_q != 9'd0);
    do_wr     = rx_vld_q && ((count_q != DEPTH_C) || do_rd);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem[rd_ptr_q];
    end
    if (do_wr && !do_rd)      count_d = count_q + 9'd1;
    else if (!do_wr && do_rd) count_d = count_q - 9'd1;
  end

  // FIFO pointers, occupancy and read register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  // FIFO storage; contents are meaningless after reset since pointers restart
  always_ff @(posedge CLK) begin
    if (do_wr) mem[wr_ptr_q] <= rx_shift_q;
  end

  assign RD_DATA = rd_data_q;
  assign COUNT   = count_q;

endmodule

// File: tb/tb_uart_rx_fifo_tx.sv
// Scoreboard bench for uart_rx_fifo_tx with CLKS_PER_BIT=16, FIFO_DEPTH=256.
module tb_uart_rx_fifo_tx;

  localparam int CPB   = 16;
  localparam int DEPTH = 256;

  logic       CLK = 1'b0;
  logic       RST_N, UART_RX, SEND, RD_EN;
  logic [7:0] SEND_DATA;
  logic       UART_TX, READY;
  logic [7:0] RD_DATA;
  logic [8:0] COUNT;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         model_cnt = 0;
  logic [7:0] sb[$];
  logic       tx_sb[$];
  logic [7:0] last_rd = 8'h00;

  uart_rx_fifo_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .UART_RX(UART_RX), .UART_TX(UART_TX),
    .SEND(SEND), .SEND_DATA(SEND_DATA), .READY(READY), .RD_EN(RD_EN),
    .RD_DATA(RD_DATA), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // drive one 8N1 frame on UART_RX; called at a negedge
  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      UART_RX = f[i];
      repeat (CPB) @(negedge CLK);
    end
    UART_RX = 1'b1;
    if (stop_bit && model_cnt < DEPTH) begin
      sb.push_back(b);
      model_cnt++;
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] e;
    RD_EN = 1'b1;
    @(negedge CLK);
    RD_EN = 1'b0;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      model_cnt--;
      chk(tag, 32'(RD_DATA), 32'(e));
      last_rd = e;
    end else begin
      chk({tag, "_hold"}, 32'(RD_DATA), 32'(last_rd));
    end
    chk({tag, "_cnt"}, 32'(COUNT), 32'(model_cnt));
  endtask

  task automatic tx_check(input logic [7:0] b);
    int  i;
    int  low;
    logic e;
    tx_sb.push_back(1'b0);
    for (int k = 0; k < 8; k++) tx_sb.push_back(b[k]);
    tx_sb.push_back(1'b1);
    SEND_DATA = b;
    SEND      = 1'b1;
    @(negedge CLK);
    SEND      = 1'b0;
    SEND_DATA = ~b;
    i   = 1;
    low = 0;
    while (READY === 1'b0 && i < 400) begin
      low++;
      if (((i - 1) % CPB) == CPB / 2 && tx_sb.size() != 0) begin
        e = tx_sb.pop_front();
        chk("tx_bit", 32'(UART_TX), 32'(e));
      end
      if (i == 20) begin
        SEND      = 1'b1;
        SEND_DATA = 8'hFF;
      end
      if (i == 21) SEND = 1'b0;
      @(negedge CLK);
      i++;
    end
    chk("tx_ready_low", 32'(low), 32'(10 * CPB));
    chk("tx_bits_left", 32'(tx_sb.size()), 32'd0);
    tx_sb.delete();
    chk("tx_idle", 32'(UART_TX), 32'd1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; UART_RX = 1'b1; SEND = 1'b0; SEND_DATA = 8'h00; RD_EN = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_tx",    32'(UART_TX), 32'd1);
    chk("rst_ready", 32'(READY),   32'd1);
    chk("rst_count", 32'(COUNT),   32'd0);
    chk("rst_rd",    32'(RD_DATA), 32'd0);
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);

    tx_check(8'h41);
    tx_check(8'h96);

    rx_frame(8'h55, 1'b1);
    repeat (2) @(negedge CLK);
    chk("rx55_count", 32'(COUNT), 32'd1);
    pop_chk("pop55");
    pop_chk("empty");

    // 5-cycle low glitch, then a frame with a bad stop bit
    UART_RX = 1'b0;
    repeat (5) @(negedge CLK);
    UART_RX = 1'b1;
    repeat (40) @(negedge CLK);
    chk("glitch_count", 32'(COUNT), 32'(model_cnt));
    rx_frame(8'h3C, 1'b0);
    repeat (20) @(negedge CLK);
    chk("badstop_count", 32'(COUNT), 32'(model_cnt));
    rx_frame(8'hA5, 1'b1);
    repeat (2) @(negedge CLK);
    pop_chk("popA5");

    // fill to full, overflow byte dropped, drain in order
    for (int b = 0; b < 256; b++) begin
      rx_frame(8'(b), 1'b1);
      repeat (2) @(negedge CLK);
    end
    rx_frame(8'hAA, 1'b1);
    repeat (2) @(negedge CLK);
    chk("full_count", 32'(COUNT), 32'd256);
    for (int b = 0; b < 256; b++) pop_chk("drain");
    chk("drained", 32'(COUNT), 32'd0);

    // pop coinciding with a write at COUNT=1
    rx_frame(8'h11, 1'b1);
    repeat (2) @(negedge CLK);
    chk("pre_sim_count", 32'(COUNT), 32'd1);
    fork
      rx_frame(8'h22, 1'b1);
      begin
        logic [7:0] e;
        repeat (155) @(negedge CLK);
        RD_EN = 1'b1;
        @(negedge CLK);
        RD_EN = 1'b0;
        e = sb.pop_front();
        model_cnt--;
        last_rd = e;
        chk("sim_rd",  32'(RD_DATA), 32'(e));
        chk("sim_cnt", 32'(COUNT),   32'd1);
      end
    join
    repeat (2) @(negedge CLK);
    chk("post_sim_count", 32'(COUNT), 32'(model_cnt));
    pop_chk("sim_next");

    // reset in the middle of a transmission with a byte in the FIFO
    rx_frame(8'h77, 1'b1);
    repeat (2) @(negedge CLK);
    chk("pre_rst_count", 32'(COUNT), 32'd1);
    SEND_DATA = 8'h00;
    SEND      = 1'b1;
    @(negedge CLK);
    SEND = 1'b0;
    repeat (50) @(negedge CLK);
    chk("midtx_line", 32'(UART_TX), 32'd0);
    RST_N   = 1'b0;
    UART_RX = 1'b0;
    #1;
    chk("mrst_tx",    32'(UART_TX), 32'd1);
    chk("mrst_ready", 32'(READY),   32'd1);
    chk("mrst_count", 32'(COUNT),   32'd0);
    chk("mrst_rd",    32'(RD_DATA), 32'd0);
    sb.delete();
    model_cnt = 0;
    last_rd   = 8'h00;
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (200) @(negedge CLK);
    chk("low_line_count", 32'(COUNT), 32'd0);
    UART_RX = 1'b1;
    repeat (4) @(negedge CLK);
    rx_frame(8'h5A, 1'b1);
    repeat (2) @(negedge CLK);
    pop_chk("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo_tx.md
UART_RX_FIFO_TX -- requirements
Module: uart_rx_fifo_tx

Interface
Parameters:
REQ-001 SHALL have CLKS_PER_BIT, default 10416: clock cycles per UART bit (100 MHz / 9600 baud).
REQ-002 SHALL have FIFO_DEPTH, default 256: receive FIFO entries (power of two).
Ports:
REQ-003 SHALL have CLK  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have RST_N  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have UART_RX  in  1  serial input, idle high.
REQ-006 SHALL have UART_TX  out  1  serial output, idle high.
REQ-007 SHALL have SEND  in  1  transmit request, sampled when READY=1.
REQ-008 SHALL have SEND_DATA  in  8  byte to transmit.
REQ-009 SHALL have READY  out  1  transmitter idle, accepts SEND.
REQ-010 SHALL have RD_EN  in  1  FIFO pop request.
REQ-011 SHALL have RD_DATA  out  8  popped byte, registered.
REQ-012 SHALL have COUNT  out  9  FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-013 SHALL frame every byte as start 0, 8 data bits LSB first, stop 1, no parity; each bit CLKS_PER_BIT cycles.
REQ-014 TX SHALL latch SEND_DATA when SEND=1 and READY=1; READY low from the next cycle.
REQ-015 TX SHALL drive start bit from the cycle after acceptance; frame lasts 10*CLKS_PER_BIT cycles.
REQ-016 TX SHALL reassert READY the cycle after the stop bit ends; UART_TX stays 1 while idle.
REQ-017 TX SHALL ignore SEND while READY=0; SEND_DATA changes after acceptance do not affect the frame.
REQ-018 RX SHALL pass UART_RX through a 2-flop synchronizer before use.
REQ-019 RX states IDLE->START->DATA->STOP->IDLE; falling edge in IDLE enters START.
REQ-020 RX SHALL recheck the line at CLKS_PER_BIT/2; if high, false start, return to IDLE.
REQ-021 RX SHALL sample data bits at mid-bit, LSB first, then the stop bit at mid-bit.
REQ-022 Stop=1: RX SHALL produce a one-cycle internal valid pulse with the byte, then return to IDLE.
REQ-023 Stop=0: byte SHALL be discarded (no write); RX returns to IDLE only after the line is high.
REQ-024 FIFO write SHALL occur on valid pulse when COUNT<FIFO_DEPTH; when full the byte is dropped.
REQ-025 FIFO pop SHALL occur when RD_EN=1 and COUNT>0; RD_DATA gets the oldest entry the next cycle.
REQ-026 RD_EN with COUNT=0 SHALL be ignored; RD_DATA holds its previous value.
REQ-027 Simultaneous write and pop SHALL leave COUNT unchanged and preserve order; allowed when full.
REQ-028 Read/write pointers SHALL be log2(FIFO_DEPTH) bits and wrap naturally; order strictly FIFO.
REQ-029 COUNT SHALL update one cycle after the write/pop event.

Reset
REQ-030 RST_N=0 SHALL immediately force UART_TX=1, READY=1, COUNT=0, RD_DATA=0, pointers 0, RX/TX state IDLE, counters 0.
REQ-031 Reset mid-frame SHALL abort TX (line high) and RX (partial byte discarded); FIFO contents lost.
REQ-032 After reset release, RX SHALL wait for a fresh falling edge; a line held low SHALL NOT start reception.

Structure
REQ-033 Shared package SHALL hold UART state enum (IDLE, START, DATA, STOP) and frame constants (DATA_BITS=8, FRAME_BITS=10).
REQ-034 SHALL be a single module with three always-block groups (TX, RX, FIFO); FIFO storage as a register array, no sub-module required.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=256)
REQ-035 Reset -> UART_TX=1, READY=1, COUNT=0, RD_DATA=0x00.
REQ-036 SEND=1, SEND_DATA=0x41 -> UART_TX bits 0,1,0,0,0,0,0,1,0,1 at 16 cycles each; READY low exactly 160 cycles.
REQ-037 RX frame 0x55 -> COUNT=1; RD_EN one cycle -> RD_DATA=0x55 next cycle, COUNT=0.
REQ-038 256 frames 0x00..0xFF then 0xAA -> COUNT=256, 0xAA dropped; 256 pops return 0x00..0xFF in order, then COUNT=0.
REQ-039 Low glitch of 5 cycles on UART_RX, and a 0x3C frame with stop=0 -> no write, COUNT unchanged.
REQ-040 RD_EN held while a frame completes at COUNT=1 -> COUNT stays 1 and data order preserved; RST_N pulse mid-TX -> UART_TX=1, READY=1 immediately.
